axi4_ar_arbiter: RTL and testbench

//  Shares one AXI4 read manager port between two read requesters (s0, s1).
//  - Arbitrates the AR channel round-robin.
//  - Tags the granted request's ID with a requester-select MSB.
//  - Routes R beats back to the owning requester using that MSB.
//  - Enforces a per-requester outstanding-burst limit.

---
 rtl/axi4_ar_arbiter_if.sv | 50 +++++
 rtl/axi4_ar_arbiter.sv | 155 +++++++++++++++
 tb/tb_axi4_ar_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_ar_arbiter_if.sv
// Bus bundle for the two-requester AXI4 read arbiter: both requester ports plus the shared manager port.
// The master modport is the arbiter's view; slave is the environment (requesters and downstream manager).
interface axi4_ar_arbiter_if #(
  parameter int ADDR_BYTES  = 1,
  parameter int DATA_BYTES  = 4,
  parameter int NUM_ID_BITS = 4
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;
  localparam int N  = NUM_ID_BITS;

  logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [AW-1:0] s0_araddr;
  logic [7:0]    s0_arlen;
  logic [N-1:0]  s0_arid, s0_rid;
  logic [DW-1:0] s0_rdata;
  logic [1:0]    s0_rresp;

  logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [AW-1:0] s1_araddr;
  logic [7:0]    s1_arlen;
  logic [N-1:0]  s1_arid, s1_rid;
  logic [DW-1:0] s1_rdata;
  logic [1:0]    s1_rresp;

  logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [N:0]    m_arid, m_rid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;

  modport master (
    input  s0_arvalid, s0_araddr, s0_arlen, s0_arid, s0_rready,
    input  s1_arvalid, s1_araddr, s1_arlen, s1_arid, s1_rready,
    output s0_arready, s0_rvalid, s0_rdata, s0_rresp, s0_rlast, s0_rid,
    output s1_arready, s1_rvalid, s1_rdata, s1_rresp, s1_rlast, s1_rid,
    output m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid
  );

  modport slave (
    output s0_arvalid, s0_araddr, s0_arlen, s0_arid, s0_rready,
    output s1_arvalid, s1_araddr, s1_arlen, s1_arid, s1_rready,
    input  s0_arready, s0_rvalid, s0_rdata, s0_rresp, s0_rlast, s0_rid,
    input  s1_arready, s1_rvalid, s1_rdata, s1_rresp, s1_rlast, s1_rid,
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid
  );
endinterface

// File: rtl/axi4_ar_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin AR grant with ID tagging, R routing by the ID tag MSB,
// and a per-requester outstanding-burst limit with a sticky error for unmatched R bursts.
module axi4_ar_arbiter #(
  parameter int ADDR_BYTES      = 1,
  parameter int DATA_BYTES      = 4,
  parameter int NUM_ID_BITS     = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              aclk,
  input  logic              areset,
  axi4_ar_arbiter_if.master bus,
  output logic              err_unexpected_r
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int N  = NUM_ID_BITS;
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic          ptr_r;
  logic [1:0][3:0] cnt_r;
  logic [AW-1:0] araddr_r, cap_addr_s;
  logic [7:0]    arlen_r, cap_len_s;
  logic [N:0]    arid_r, cap_id_s;
  logic          elig0_s, elig1_s, grant_s, gsel_s, ar_hs_s;
  logic          rsel_s, m_rready_s, r_done_s;
  logic [1:0]    inc_s, dec_s;

  // Eligibility and capture-field mux for the requester being granted
  always_comb begin
    elig0_s = bus.s0_arvalid && (cnt_r[0] < MAX_OUT);
    elig1_s = bus.s1_arvalid && (cnt_r[1] < MAX_OUT);
    if (gsel_s) begin
      cap_addr_s = bus.s1_araddr;
      cap_len_s  = bus.s1_arlen;
      cap_id_s   = {1'b1, bus.s1_arid};
    end else begin
      cap_addr_s = bus.s0_araddr;
      cap_len_s  = bus.s0_arlen;
      cap_id_s   = {1'b0, bus.s0_arid};
    end
  end

  // AR FSM next-state and grant decode; the pointer only matters when both are eligible
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    gsel_s      = 1'b0;
    ar_hs_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (elig0_s && (!elig1_s || !ptr_r)) begin
          grant_s     = 1'b1;
          gsel_s      = 1'b0;
          state_nxt_s = ST_BUSY;
        end else if (elig1_s) begin
          grant_s     = 1'b1;
          gsel_s      = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.m_arready) begin
          ar_hs_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and round-robin pointer (moves to the other side after each AR handshake)
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= ST_IDLE;
      ptr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (ar_hs_s) begin
        ptr_r <= ~arid_r[N];
      end
    end
  end

  // Registered manager AR fields, loaded only in the grant cycle and held through BUSY
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      araddr_r <= '0;
      arlen_r  <= 8'd0;
      arid_r   <= '0;
    end else if (grant_s) begin
      araddr_r <= cap_addr_s;
      arlen_r  <= cap_len_s;
      arid_r   <= cap_id_s;
    end
  end

  // Areset masks the combinational grant so requesters never see arready while held in reset
  assign bus.s0_arready = grant_s && !gsel_s && !areset;
  assign bus.s1_arready = grant_s &&  gsel_s && !areset;
  assign bus.m_arvalid  = (state_r == ST_BUSY);
  assign bus.m_araddr   = araddr_r;
  assign bus.m_arlen    = arlen_r;
  assign bus.m_arid     = arid_r;

  // R path: only rvalid is steered; payload fans out to both requesters
  always_comb begin
    rsel_s = bus.m_rid[N];
    if (rsel_s) begin
      m_rready_s = bus.s1_rready;
    end else begin
      m_rready_s = bus.s0_rready;
    end
    r_done_s = bus.m_rvalid && m_rready_s && bus.m_rlast;
    inc_s    = {ar_hs_s && arid_r[N], ar_hs_s && !arid_r[N]};
    dec_s    = {r_done_s && rsel_s, r_done_s && !rsel_s};
  end

  assign bus.m_rready  = m_rready_s;
  assign bus.s0_rvalid = bus.m_rvalid && !rsel_s;
  assign bus.s1_rvalid = bus.m_rvalid &&  rsel_s;
  assign bus.s0_rdata  = bus.m_rdata;
  assign bus.s1_rdata  = bus.m_rdata;
  assign bus.s0_rresp  = bus.m_rresp;
  assign bus.s1_rresp  = bus.m_rresp;
  assign bus.s0_rlast  = bus.m_rlast;
  assign bus.s1_rlast  = bus.m_rlast;
  assign bus.s0_rid    = bus.m_rid[N-1:0];
  assign bus.s1_rid    = bus.m_rid[N-1:0];

  // Outstanding counters; a completion against an empty counter saturates at 0 and flags the error
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_r            <= '0;
      err_unexpected_r <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (inc_s[i] && !dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + 4'd1;
        end else if (dec_s[i] && !inc_s[i]) begin
          if (cnt_r[i] == 4'd0) begin
            err_unexpected_r <= 1'b1;
          end else begin
            cnt_r[i] <= cnt_r[i] - 4'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4_ar_arbiter.sv
// Self-checking bench for axi4_ar_arbiter: directed sequences, an R-routing vector table,
// and randomized traffic compared against a transaction-level reference model.
module tb_axi4_ar_arbiter;
  localparam int AB = 1;
  localparam int DB = 4;
  localparam int NB = 4;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  logic err;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi4_ar_arbiter_if #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .NUM_ID_BITS(NB)) bus ();

  axi4_ar_arbiter #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .NUM_ID_BITS(NB), .MAX_OUTSTANDING(MO)) dut (
    .aclk(clk), .areset(rst), .bus(bus), .err_unexpected_r(err)
  );

  typedef struct {
    logic       m_rvalid;
    logic [4:0] m_rid;
    logic       s0_rready;
    logic       s1_rready;
    logic       e_s0_rvalid;
    logic       e_s1_rvalid;
    logic       e_m_rready;
    logic [3:0] e_rid;
  } rvec_t;

  rvec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    bus.s0_arvalid = 1'b0; bus.s0_araddr = 8'h00; bus.s0_arlen = 8'h00; bus.s0_arid = 4'h0;
    bus.s1_arvalid = 1'b0; bus.s1_araddr = 8'h00; bus.s1_arlen = 8'h00; bus.s1_arid = 4'h0;
    bus.s0_rready = 1'b0; bus.s1_rready = 1'b0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
    bus.m_rresp = 2'b00; bus.m_rlast = 1'b0; bus.m_rid = 5'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model state for the random phase
  bit         pend, psel, ptr, merr;
  int         cnt [2];
  logic [7:0] addr_h, len_h;
  logic [4:0] id_h;

  initial begin
    tbl[0] = '{1'b1, 5'h13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3};
    tbl[1] = '{1'b1, 5'h13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3};
    tbl[2] = '{1'b1, 5'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5};
    tbl[3] = '{1'b1, 5'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5};
    tbl[4] = '{1'b0, 5'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF};
    tbl[5] = '{1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};

    // Reset state, with a request pending to show arready stays low
    rst = 1'b1;
    quiet();
    bus.s0_arvalid = 1'b1;
    @(negedge clk); #1;
    chk("rst_m_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_m_araddr", bus.m_araddr, 8'h00);
    chk("rst_m_arlen", bus.m_arlen, 8'h00);
    chk("rst_m_arid", bus.m_arid, 5'h00);
    chk("rst_s0_arready", bus.s0_arready, 1'b0);
    chk("rst_s1_arready", bus.s1_arready, 1'b0);
    chk("rst_err", err, 1'b0);

    // Single s0 request
    do_reset();
    bus.s0_arvalid = 1'b1; bus.s0_araddr = 8'h10; bus.s0_arlen = 8'd3; bus.s0_arid = 4'h2;
    bus.m_arready = 1'b1;
    #1;
    chk("t1_s0_arready", bus.s0_arready, 1'b1);
    chk("t1_s1_arready", bus.s1_arready, 1'b0);
    chk("t1_arvalid_pre", bus.m_arvalid, 1'b0);
    @(negedge clk);
    bus.s0_arvalid = 1'b0;
    #1;
    chk("t1_arvalid", bus.m_arvalid, 1'b1);
    chk("t1_arid", bus.m_arid, 5'h02);
    chk("t1_araddr", bus.m_araddr, 8'h10);
    chk("t1_arlen", bus.m_arlen, 8'd3);
    chk("t1_s0_arready_busy", bus.s0_arready, 1'b0);
    @(negedge clk); #1;
    chk("t1_arvalid_post", bus.m_arvalid, 1'b0);

    // Round-robin alternation with both requesters always valid
    do_reset();
    bus.s0_arvalid = 1'b1; bus.s0_arid = 4'h5;
    bus.s1_arvalid = 1'b1; bus.s1_arid = 4'hA;
    bus.m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_s0_arready", bus.s0_arready, (k % 2) == 0);
      chk("t2_s1_arready", bus.s1_arready, (k % 2) == 1);
      @(negedge clk); #1;
      chk("t2_arid", bus.m_arid, ((k % 2) == 1) ? 5'h1A : 5'h05);
      @(negedge clk);
    end

    // Outstanding limit on s1, then release by a completed burst
    do_reset();
    bus.s1_arvalid = 1'b1; bus.m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_s1_grant", bus.s1_arready, 1'b1);
      @(negedge clk);
      @(negedge clk);
    end
    bus.s0_arvalid = 1'b1;
    #1;
    chk("t3_s1_stall", bus.s1_arready, 1'b0);
    chk("t3_s0_grant", bus.s0_arready, 1'b1);
    @(negedge clk);
    bus.s0_arvalid = 1'b0;
    #1;
    chk("t3_s0_arid_msb", bus.m_arid[4], 1'b0);
    @(negedge clk); #1;
    chk("t3_s1_stall2", bus.s1_arready, 1'b0);
    bus.s1_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.m_rvalid = 1'b1; bus.m_rid = 5'h12; bus.m_rlast = (b == 3);
      #1;
      chk("t3_s1_rvalid", bus.s1_rvalid, 1'b1);
      chk("t3_m_rready", bus.m_rready, 1'b1);
      chk("t3_s1_stall_r", bus.s1_arready, 1'b0);
      @(negedge clk);
    end
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
    #1;
    chk("t3_s1_regrant", bus.s1_arready, 1'b1);

    // Backpressure on s1's R channel
    do_reset();
    bus.m_rvalid = 1'b1; bus.m_rid = 5'h13; bus.s0_rready = 1'b1; bus.s1_rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_m_rready_hold", bus.m_rready, 1'b0);
      chk("t4_s0_rvalid", bus.s0_rvalid, 1'b0);
      chk("t4_s1_rvalid", bus.s1_rvalid, 1'b1);
      chk("t4_s1_rid", bus.s1_rid, 4'h3);
      @(negedge clk);
    end
    bus.s1_rready = 1'b1;
    #1;
    chk("t4_m_rready_go", bus.m_rready, 1'b1);
    chk("t4_s0_rvalid_go", bus.s0_rvalid, 1'b0);
    @(negedge clk);

    // R routing vector table
    for (int i = 0; i < 6; i++) begin
      bus.m_rvalid = tbl[i].m_rvalid; bus.m_rid = tbl[i].m_rid; bus.m_rlast = 1'b0;
      bus.s0_rready = tbl[i].s0_rready; bus.s1_rready = tbl[i].s1_rready;
      #1;
      chk("tv_s0_rvalid", bus.s0_rvalid, tbl[i].e_s0_rvalid);
      chk("tv_s1_rvalid", bus.s1_rvalid, tbl[i].e_s1_rvalid);
      chk("tv_m_rready", bus.m_rready, tbl[i].e_m_rready);
      chk("tv_s0_rid", bus.s0_rid, tbl[i].e_rid);
      @(negedge clk);
    end

    // Unexpected R burst for s0: sticky error, counter stays at zero
    do_reset();
    bus.m_rvalid = 1'b1; bus.m_rid = 5'h00; bus.m_rlast = 1'b1; bus.s0_rready = 1'b1;
    bus.m_rdata = 32'hCAFE_0001;
    #1;
    chk("t5_s0_rvalid", bus.s0_rvalid, 1'b1);
    chk("t5_s0_rdata", bus.s0_rdata, 32'hCAFE_0001);
    chk("t5_err_before", err, 1'b0);
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
    #1;
    chk("t5_err_set", err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_err_sticky", err, 1'b1);
    bus.s0_arvalid = 1'b1; bus.m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_s0_grant", bus.s0_arready, 1'b1);
      @(negedge clk);
      @(negedge clk);
    end
    #1;
    chk("t5_s0_stall", bus.s0_arready, 1'b0);

    // Reset in the middle of a stalled AR
    do_reset();
    bus.s1_arvalid = 1'b1; bus.m_arready = 1'b1;
    #1;
    chk("t6_s1_first", bus.s1_arready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.s1_arvalid = 1'b0; bus.s0_arvalid = 1'b1; bus.m_arready = 1'b0;
    #1;
    chk("t6_s0_grant", bus.s0_arready, 1'b1);
    @(negedge clk);
    bus.s0_arvalid = 1'b0;
    #1;
    chk("t6_busy", bus.m_arvalid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_arvalid_async", bus.m_arvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.s0_arvalid = 1'b1; bus.s1_arvalid = 1'b1; bus.m_arready = 1'b1;
    #1;
    chk("t6_ptr_s0", bus.s0_arready, 1'b1);
    chk("t6_ptr_s1", bus.s1_arready, 1'b0);
    @(negedge clk);
    bus.s0_arvalid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_s1_grant", bus.s1_arready, 1'b1);
      @(negedge clk);
      @(negedge clk);
    end
    #1;
    chk("t6_s1_stall", bus.s1_arready, 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    pend = 1'b0; psel = 1'b0; ptr = 1'b0; merr = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    addr_h = 8'h00; len_h = 8'h00; id_h = 5'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit e0, e1, g, gs, rs, mr, hs;
      bus.s0_arvalid = ($urandom_range(0, 99) < 60);
      bus.s1_arvalid = ($urandom_range(0, 99) < 60);
      bus.s0_araddr = 8'($urandom); bus.s0_arlen = 8'($urandom); bus.s0_arid = 4'($urandom);
      bus.s1_araddr = 8'($urandom); bus.s1_arlen = 8'($urandom); bus.s1_arid = 4'($urandom);
      bus.m_arready = ($urandom_range(0, 99) < 50);
      bus.m_rvalid = ($urandom_range(0, 99) < ((cyc < 1500) ? 20 : 45));
      bus.m_rid = 5'($urandom); bus.m_rlast = 1'($urandom);
      bus.m_rdata = $urandom; bus.m_rresp = 2'($urandom);
      bus.s0_rready = 1'($urandom); bus.s1_rready = 1'($urandom);
      #1;
      e0 = bus.s0_arvalid && (cnt[0] < MO);
      e1 = bus.s1_arvalid && (cnt[1] < MO);
      g  = !pend && (e0 || e1);
      gs = !(e0 && (!e1 || !ptr));
      rs = bus.m_rid[4];
      mr = rs ? bus.s1_rready : bus.s0_rready;
      chk("rnd_s0_arready", bus.s0_arready, g && !gs);
      chk("rnd_s1_arready", bus.s1_arready, g && gs);
      chk("rnd_m_arvalid", bus.m_arvalid, pend);
      chk("rnd_m_arid", bus.m_arid, id_h);
      chk("rnd_m_araddr", bus.m_araddr, addr_h);
      chk("rnd_m_arlen", bus.m_arlen, len_h);
      chk("rnd_s0_rvalid", bus.s0_rvalid, bus.m_rvalid && !rs);
      chk("rnd_s1_rvalid", bus.s1_rvalid, bus.m_rvalid && rs);
      chk("rnd_m_rready", bus.m_rready, mr);
      chk("rnd_s1_rid", bus.s1_rid, bus.m_rid[3:0]);
      chk("rnd_s0_rdata", bus.s0_rdata, bus.m_rdata);
      chk("rnd_err", err, merr);
      hs = pend && bus.m_arready;
      for (int i = 0; i < 2; i++) begin
        bit inc, dec;
        inc = hs && (psel == i[0]);
        dec = bus.m_rvalid && mr && bus.m_rlast && (rs == i[0]);
        if (inc && !dec) cnt[i]++;
        else if (dec && !inc) begin
          if (cnt[i] == 0) merr = 1'b1;
          else cnt[i]--;
        end
      end
      if (hs) begin
        pend = 1'b0;
        ptr  = !psel;
      end
      if (g) begin
        pend   = 1'b1;
        psel   = gs;
        addr_h = gs ? bus.s1_araddr : bus.s0_araddr;
        len_h  = gs ? bus.s1_arlen : bus.s0_arlen;
        id_h   = gs ? {1'b1, bus.s1_arid} : {1'b0, bus.s0_arid};
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
